// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester-side and pmem-side bus bundle for the memory arbiter
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;
  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_wdata, pmem_rdata, pmem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
  );
  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_wdata, pmem_rdata, pmem_resp,
    output i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of one pmem port between I-side and D-side cache misses
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input logic          clk,
  input logic          rst_n,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, RECOVER} state_t;
  state_t            state, next_state;
  logic              last_grant;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LINE_W-1:0] cmd_wdata;
  logic              cmd_is_write;
  logic              i_req, d_req, grant_i, grant_d, busy;
  // on a contest the side that did not win last time gets the port
  always_comb begin
    i_req   = bus.i_read;
    d_req   = bus.d_read | bus.d_write;
    grant_i = i_req & (~d_req | last_grant);
    grant_d = d_req & (~i_req | ~last_grant);
    busy    = (state == I_BUSY) | (state == D_BUSY);
    next_state = state;
    case (state)
      IDLE:    next_state = grant_i ? I_BUSY : grant_d ? D_BUSY : IDLE;
      I_BUSY,
      D_BUSY:  next_state = bus.pmem_resp ? RECOVER : state;
      default: next_state = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      cmd_addr     <= '0;
      cmd_wdata    <= '0;
      cmd_is_write <= 1'b0;
    end else begin
      state <= next_state;
      if (state == IDLE && (grant_i || grant_d)) begin
        cmd_addr     <= grant_i ? bus.i_address : bus.d_address;
        cmd_wdata    <= bus.d_wdata;
        cmd_is_write <= grant_d & bus.d_write;
        last_grant   <= grant_d;
      end
    end
  end
  // command is a pure function of registers, so pmem sees it stable all transaction
  always_comb begin
    bus.pmem_read    = busy & ~cmd_is_write;
    bus.pmem_write   = busy & cmd_is_write;
    bus.pmem_address = busy ? cmd_addr : '0;
    bus.pmem_wdata   = busy ? cmd_wdata : '0;
    bus.i_resp       = (state == I_BUSY) & bus.pmem_resp;
    bus.d_resp       = (state == D_BUSY) & bus.pmem_resp;
    bus.i_rdata      = bus.i_resp ? bus.pmem_rdata : '0;
    bus.d_rdata      = bus.d_resp ? bus.pmem_rdata : '0;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of grant order, latency, command latching and async reset
module tb_mem_arbiter;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [LINE_W-1:0] pat_a5;
  mem_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();
  mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    pat_a5 = {32{8'hA5}};
    bus.i_read = 0; bus.i_address = '0; bus.d_read = 0; bus.d_write = 0;
    bus.d_address = '0; bus.d_wdata = '0; bus.pmem_rdata = '0; bus.pmem_resp = 0;
    tick; tick;
    chk("rst_pmem_read", bus.pmem_read, 0);
    chk("rst_pmem_write", bus.pmem_write, 0);
    chk("rst_pmem_addr", bus.pmem_address, 0);
    chk("rst_resp", {bus.i_resp, bus.d_resp}, 0);
    rst_n = 1;
    tick;
    // I read, response on 4th busy cycle
    bus.i_read = 1; bus.i_address = 32'h60;
    #1 chk("t1_no_cmd_idle", bus.pmem_read, 0);
    tick;
    chk("t1_pmem_read", bus.pmem_read, 1);
    chk("t1_pmem_addr", bus.pmem_address, 32'h60);
    chk("t1_pmem_write", bus.pmem_write, 0);
    tick; tick;
    chk("t1_no_early_resp", bus.i_resp, 0);
    chk("t1_rdata_zero", bus.i_rdata, 0);
    tick;
    bus.pmem_rdata = pat_a5; bus.pmem_resp = 1;
    #1 chk("t1_i_resp", bus.i_resp, 1);
    chk("t1_i_rdata", bus.i_rdata, pat_a5);
    chk("t1_d_resp", bus.d_resp, 0);
    chk("t1_d_rdata", bus.d_rdata, 0);
    chk("t1_cmd_on_resp", bus.pmem_read, 1);
    tick;
    bus.pmem_resp = 0; bus.i_read = 0;
    #1 chk("t1_recover_no_cmd", bus.pmem_read, 0);
    chk("t1_recover_no_resp", bus.i_resp, 0);
    tick;
    // D write, then mid-transaction changes must not disturb the latched command
    bus.d_write = 1; bus.d_address = 32'h100; bus.d_wdata = 256'h1234;
    tick;
    chk("t2_pmem_write", bus.pmem_write, 1);
    chk("t2_pmem_read", bus.pmem_read, 0);
    chk("t2_pmem_wdata", bus.pmem_wdata, 256'h1234);
    chk("t2_pmem_addr", bus.pmem_address, 32'h100);
    bus.d_address = 32'h200; bus.i_read = 1; bus.i_address = 32'h300;
    tick;
    chk("t4_addr_latched", bus.pmem_address, 32'h100);
    chk("t4_still_write", bus.pmem_write, 1);
    bus.pmem_rdata = pat_a5; bus.pmem_resp = 1;
    #1 chk("t2_d_resp", bus.d_resp, 1);
    chk("t2_i_resp", bus.i_resp, 0);
    chk("t2_i_rdata", bus.i_rdata, 0);
    tick;
    bus.pmem_resp = 0; bus.d_write = 0;
    #1 chk("t2_recover_no_cmd", {bus.pmem_read, bus.pmem_write}, 0);
    chk("t2_d_resp_once", bus.d_resp, 0);
    tick;
    chk("t4_idle_no_cmd", bus.pmem_read, 0);
    tick;
    chk("t4_i_granted", bus.pmem_read, 1);
    chk("t4_i_addr", bus.pmem_address, 32'h300);
    bus.pmem_resp = 1;
    #1 chk("t4_i_resp", bus.i_resp, 1);
    tick;
    bus.pmem_resp = 0; bus.i_read = 0;
    tick;
    // round robin from a fresh reset
    rst_n = 0;
    tick;
    rst_n = 1;
    bus.i_read = 1; bus.d_read = 1; bus.i_address = 32'h40; bus.d_address = 32'h80;
    tick;
    for (int k = 0; k < 4; k++) begin
      tick;
      chk($sformatf("rr%0d_addr", k), bus.pmem_address, (k % 2 == 0) ? 32'h40 : 32'h80);
      chk($sformatf("rr%0d_read", k), bus.pmem_read, 1);
      tick; tick;
      bus.pmem_rdata = LINE_W'(k + 1); bus.pmem_resp = 1;
      #1 chk($sformatf("rr%0d_i_resp", k), bus.i_resp, (k % 2 == 0) ? 1'b1 : 1'b0);
      chk($sformatf("rr%0d_d_resp", k), bus.d_resp, (k % 2 == 0) ? 1'b0 : 1'b1);
      chk($sformatf("rr%0d_rdata", k), (k % 2 == 0) ? bus.i_rdata : bus.d_rdata, LINE_W'(k + 1));
      tick;
      bus.pmem_resp = (k == 0);
      #1 chk($sformatf("rr%0d_recover", k), {bus.pmem_read, bus.i_resp, bus.d_resp}, 0);
      bus.pmem_resp = 0;
      tick;
      chk($sformatf("rr%0d_idle", k), bus.pmem_read, 0);
    end
    // async reset in the middle of an I transaction
    bus.d_read = 0; bus.i_address = 32'h60;
    tick;
    chk("t5_busy", bus.pmem_read, 1);
    #2 rst_n = 0;
    #1 chk("t5_async_read_drop", bus.pmem_read, 0);
    chk("t5_async_addr_drop", bus.pmem_address, 0);
    bus.i_read = 0;
    tick;
    rst_n = 1;
    bus.pmem_resp = 1;
    #1 chk("t5_late_resp_ignored", bus.i_resp, 0);
    tick;
    bus.pmem_resp = 0;
    #1 chk("t5_idle", {bus.pmem_read, bus.pmem_write}, 0);
    // read and write together count as a write
    bus.d_read = 1; bus.d_write = 1; bus.d_address = 32'h500; bus.d_wdata = 256'hBEEF;
    tick;
    chk("t6_write", bus.pmem_write, 1);
    chk("t6_no_read", bus.pmem_read, 0);
    chk("t6_wdata", bus.pmem_wdata, 256'hBEEF);
    bus.pmem_resp = 1;
    #1 chk("t6_d_resp", bus.d_resp, 1);
    tick;
    bus.pmem_resp = 0; bus.d_read = 0; bus.d_write = 0;
    tick;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
